// File: rtl/xsim_dma_burst_adapter_pkg.sv
// Shared types and constants for the burst-to-word DMA adapter.
package xsim_dma_burst_adapter_pkg;

    localparam int unsigned LENW = 32'd8;
    localparam int unsigned TAGW = 32'd6;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0]     handle;
        logic [31:0]     addr;
        logic [LENW-1:0] len;
        logic [TAGW-1:0] tag;
    } burst_desc_t;

endpackage

// File: rtl/xsim_dma_burst_adapter_if.sv
// Client burst ports and DMA word ports of the adapter, grouped as one bundle.
interface xsim_dma_burst_adapter_if import xsim_dma_burst_adapter_pkg::*;;

    logic            en_readreq, rdy_readreq;
    logic [31:0]     readreq_handle, readreq_addr;
    logic [LENW-1:0] readreq_len;
    logic [TAGW-1:0] readreq_tag;
    logic            en_readdata, rdy_readdata, readdata_last;
    logic [31:0]     readdata_data;
    logic [TAGW-1:0] readdata_tag;
    logic            en_writereq, rdy_writereq;
    logic [31:0]     writereq_handle, writereq_addr;
    logic [LENW-1:0] writereq_len;
    logic [TAGW-1:0] writereq_tag;
    logic            en_writedata, rdy_writedata;
    logic [31:0]     writedata_data;
    logic            en_writedone, rdy_writedone;
    logic [TAGW-1:0] writedone_tag;
    logic            dma_en_readrequest, dma_rdy_readrequest;
    logic [31:0]     dma_readrequest_addr, dma_readrequest_handle;
    logic            dma_rdy_readresponse, dma_en_readresponse;
    logic [31:0]     dma_readresponse_data;
    logic            dma_en_write32;
    logic [31:0]     dma_write32_addr, dma_write32_handle, dma_write32_data;

    modport slave (
        input  en_readreq, readreq_handle, readreq_addr, readreq_len, readreq_tag,
        output rdy_readreq,
        input  en_readdata,
        output rdy_readdata, readdata_data, readdata_tag, readdata_last,
        input  en_writereq, writereq_handle, writereq_addr, writereq_len, writereq_tag,
        output rdy_writereq,
        input  en_writedata, writedata_data,
        output rdy_writedata,
        input  en_writedone,
        output rdy_writedone, writedone_tag,
        output dma_en_readrequest, dma_readrequest_addr, dma_readrequest_handle,
        input  dma_rdy_readrequest,
        input  dma_rdy_readresponse, dma_readresponse_data,
        output dma_en_readresponse,
        output dma_en_write32, dma_write32_addr, dma_write32_handle, dma_write32_data
    );

    modport master (
        output en_readreq, readreq_handle, readreq_addr, readreq_len, readreq_tag,
        input  rdy_readreq,
        output en_readdata,
        input  rdy_readdata, readdata_data, readdata_tag, readdata_last,
        output en_writereq, writereq_handle, writereq_addr, writereq_len, writereq_tag,
        input  rdy_writereq,
        output en_writedata, writedata_data,
        input  rdy_writedata,
        output en_writedone,
        input  rdy_writedone, writedone_tag,
        input  dma_en_readrequest, dma_readrequest_addr, dma_readrequest_handle,
        output dma_rdy_readrequest,
        output dma_rdy_readresponse, dma_readresponse_data,
        input  dma_en_readresponse,
        input  dma_en_write32, dma_write32_addr, dma_write32_handle, dma_write32_data
    );

endinterface

// File: rtl/xsim_dma_burst_adapter_addr_gen.sv
// Word address/count generator for the active burst; shared by reads and writes.
module xsim_burst_addr_gen import xsim_dma_burst_adapter_pkg::*; (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [31:0]     base_i,
    input  logic [LENW-1:0] len_i,
    output logic [31:0]     addr_o,
    output logic [LENW-1:0] cnt_o,
    output logic            last_o
);

    logic [31:0]     addr_q;
    logic [LENW-1:0] cnt_q;

    // Address register advances one word per step and wraps modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= 32'd0;
            cnt_q  <= '0;
        end else if (load_i) begin
            addr_q <= base_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            addr_q <= addr_q + WORD_BYTES;
            cnt_q  <= cnt_q + LENW'(1'b1);
        end else begin
            addr_q <= addr_q;
            cnt_q  <= cnt_q;
        end
    end

    assign addr_o = addr_q;
    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == (len_i - LENW'(1'b1)));

endmodule

// File: rtl/xsim_dma_burst_adapter.sv
// Splits tagged client bursts into single 32-bit DMA word accesses, one burst at a time.
module xsim_dma_burst_adapter import xsim_dma_burst_adapter_pkg::*; (
    input  logic                     CLK,
    input  logic                     RST,
    xsim_dma_burst_adapter_if.slave  bus
);

    state_e          state_q, state_d;
    burst_desc_t     desc_q, desc_d;
    logic            rr_last_q, rr_last_d;
    logic [LENW-1:0] ret_cnt_q, ret_cnt_d;

    logic            rdy_rd_s, rdy_wr_s, rd_valid_s, rd_last_s, rd_issue_s, rsp_pop_s;
    logic            wd_rdy_s, wr_issue_s, wdone_s;
    logic            gen_load_s, gen_step_s, gen_last_s, more_s, ret_last_s;
    logic [31:0]     gen_base_s, gen_addr_s;
    logic [LENW-1:0] gen_cnt_s;

    xsim_burst_addr_gen u_addr_gen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (gen_load_s),
        .step_i (gen_step_s),
        .base_i (gen_base_s),
        .len_i  (desc_q.len),
        .addr_o (gen_addr_s),
        .cnt_o  (gen_cnt_s),
        .last_o (gen_last_s)
    );

    assign more_s     = (gen_cnt_s < desc_q.len);
    assign ret_last_s = (ret_cnt_q == (desc_q.len - LENW'(1'b1)));

    // Next-state and handshake decode; rr_last_q=1 means the last grant went to a read.
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        rr_last_d  = rr_last_q;
        ret_cnt_d  = ret_cnt_q;
        gen_load_s = 1'b0;
        gen_step_s = 1'b0;
        gen_base_s = bus.readreq_addr;
        rdy_rd_s   = 1'b0;
        rdy_wr_s   = 1'b0;
        rd_valid_s = 1'b0;
        rd_last_s  = 1'b0;
        rd_issue_s = 1'b0;
        rsp_pop_s  = 1'b0;
        wd_rdy_s   = 1'b0;
        wr_issue_s = 1'b0;
        wdone_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy_rd_s  = ~(bus.en_readreq & bus.en_writereq & rr_last_q);
                rdy_wr_s  = ~(bus.en_readreq & bus.en_writereq & ~rr_last_q);
                rsp_pop_s = bus.dma_rdy_readresponse;
                if (bus.en_readreq && rdy_rd_s) begin
                    desc_d     = '{handle: bus.readreq_handle, addr: bus.readreq_addr,
                                   len: bus.readreq_len, tag: bus.readreq_tag};
                    ret_cnt_d  = '0;
                    gen_load_s = 1'b1;
                    gen_base_s = bus.readreq_addr;
                    rr_last_d  = 1'b1;
                    state_d    = (bus.readreq_len != '0) ? ST_RD : ST_IDLE;
                end else if (bus.en_writereq && rdy_wr_s) begin
                    desc_d     = '{handle: bus.writereq_handle, addr: bus.writereq_addr,
                                   len: bus.writereq_len, tag: bus.writereq_tag};
                    ret_cnt_d  = '0;
                    gen_load_s = 1'b1;
                    gen_base_s = bus.writereq_addr;
                    rr_last_d  = 1'b0;
                    state_d    = (bus.writereq_len != '0) ? ST_WR : ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                rd_issue_s = more_s & bus.dma_rdy_readrequest;
                gen_step_s = rd_issue_s;
                rd_valid_s = bus.dma_rdy_readresponse;
                rd_last_s  = ret_last_s;
                rsp_pop_s  = bus.en_readdata & bus.dma_rdy_readresponse;
                if (rsp_pop_s) begin
                    ret_cnt_d = ret_cnt_q + LENW'(1'b1);
                    state_d   = ret_last_s ? ST_IDLE : ST_RD;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                wd_rdy_s   = more_s;
                wr_issue_s = bus.en_writedata & more_s;
                gen_step_s = wr_issue_s;
                rsp_pop_s  = bus.dma_rdy_readresponse;
                if (wr_issue_s && gen_last_s) begin
                    state_d = ST_WR_DONE;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR_DONE: begin
                wdone_s   = 1'b1;
                rsp_pop_s = bus.dma_rdy_readresponse;
                if (bus.en_writedone) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst state, descriptor, arbitration history and return counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            desc_q    <= '0;
            rr_last_q <= 1'b0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            desc_q    <= desc_d;
            rr_last_q <= rr_last_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // Strobes are forced low during reset because the state register updates only at the edge.
    assign bus.rdy_readreq            = rdy_rd_s & ~RST;
    assign bus.rdy_writereq           = rdy_wr_s & ~RST;
    assign bus.rdy_readdata           = rd_valid_s & ~RST;
    assign bus.readdata_last          = rd_last_s & ~RST;
    assign bus.readdata_data          = bus.dma_readresponse_data;
    assign bus.readdata_tag           = desc_q.tag;
    assign bus.rdy_writedata          = wd_rdy_s & ~RST;
    assign bus.rdy_writedone          = wdone_s & ~RST;
    assign bus.writedone_tag          = desc_q.tag;
    assign bus.dma_en_readrequest     = rd_issue_s & ~RST;
    assign bus.dma_readrequest_addr   = gen_addr_s;
    assign bus.dma_readrequest_handle = desc_q.handle;
    assign bus.dma_en_readresponse    = rsp_pop_s & ~RST;
    assign bus.dma_en_write32         = wr_issue_s & ~RST;
    assign bus.dma_write32_addr       = gen_addr_s;
    assign bus.dma_write32_handle     = desc_q.handle;
    assign bus.dma_write32_data       = bus.writedata_data;

endmodule

// File: doc/xsim_dma_burst_adapter.md
Name: xsim_dma_burst_adapter

Overview:
Sits directly upstream of the simulation word-DMA block, which takes one 32-bit read or write per request. Accepts tagged burst read and burst write requests from a memory client. Splits each burst into sequential 32-bit word accesses on the DMA word interface. Returns read data beats with tag and last flag, and returns a write-done token per write burst. One burst is in flight at a time.

Parameters:
LENW, 8, width of burst length field in beats (max burst 2^LENW-1)
TAGW, 6, width of client tag

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
en_readreq  in  1  client read-burst request strobe
rdy_readreq  out  1  adapter can accept read request
readreq_handle  in  32  memory handle
readreq_addr  in  32  byte start address, 4-aligned
readreq_len  in  LENW  beats
readreq_tag  in  TAGW  tag
en_readdata  in  1  client consumes read beat
rdy_readdata  out  1  read beat valid
readdata_data  out  32  beat data
readdata_tag  out  TAGW  burst tag
readdata_last  out  1  final beat of burst
en_writereq / rdy_writereq / writereq_handle / writereq_addr / writereq_len / writereq_tag  as read-request group, for writes
en_writedata  in  1  client supplies write beat
rdy_writedata  out  1  adapter accepts write beat
writedata_data  in  32  beat data
en_writedone  in  1  client consumes completion
rdy_writedone  out  1  completion valid
writedone_tag  out  TAGW  tag of completed burst
dma_en_readrequest  out  1  word read issue
dma_rdy_readrequest  in  1  DMA can accept read
dma_readrequest_addr / dma_readrequest_handle  out  32 each
dma_rdy_readresponse  in  1  DMA response valid
dma_readresponse_data  in  32  response data
dma_en_readresponse  out  1  consume DMA response
dma_en_write32  out  1  word write issue (always accepted)
dma_write32_addr / dma_write32_handle / dma_write32_data  out  32 each

Behaviour:
- States: IDLE, RD, WR, WR_DONE. Reset (RST=1 at posedge) -> IDLE. Counters, tag, address and rr_last are cleared. Every rdy_* and dma_en_* output is 0 while RST=1.
- IDLE: rdy_readreq=1 and rdy_writereq=1, except when both en_ strobes are high in the same cycle. In that case the grant goes to the type not served last (rr_last; read wins first after reset) and only the winner's rdy is high.
- An accepted request latches handle, addr, len and tag, and clears issue_cnt and ret_cnt. len=0 is accepted and ignored: no DMA traffic, no data beat, no write completion, stay IDLE.
- RD: dma_en_readrequest = (issue_cnt<len) && dma_rdy_readrequest. Address is base+4*issue_cnt, mod 2^32 (wraps). issue_cnt increments on issue.
- RD: rdy_readdata = dma_rdy_readresponse. readdata_data = dma_readresponse_data, passed combinationally. dma_en_readresponse = en_readdata.
- RD: readdata_last = (ret_cnt==len-1). ret_cnt increments per consumed beat. After the last beat is consumed, next state is IDLE.
- RD pipelining: at most 1 word is outstanding, as enforced by DMA rdy. Back-to-back issue is allowed in the cycle the previous response is consumed.
- WR: rdy_writedata=1 while issue_cnt<len. en_writedata drives dma_en_write32 in the same cycle with address base+4*issue_cnt (wraps) and data writedata_data. After beat len-1, next state is WR_DONE.
- WR_DONE: rdy_writedone=1 and writedone_tag is the latched tag. On en_writedone, next state is IDLE.
- Throughput: 1 write word per cycle. Reads run 1 word per cycle when the client and DMA never stall.
- Request rdy stays 0 outside IDLE. There is no overlap between bursts.
- Stale DMA response (dma_rdy_readresponse high in IDLE, WR or WR_DONE, e.g. after reset mid-read): drained by asserting dma_en_readresponse. Nothing is forwarded to the client.
- Client en_ strobes asserted while the matching rdy=0 are ignored.

Decomposition:
- Shared package: state enum, WORD_BYTES=4 constant, and a burst-descriptor struct {handle, addr, len, tag}.
- One sub-module: xsim_burst_addr_gen. It takes base and len, provides load/step controls, and outputs the current address, count and last flag. It is instantiated once and shared between RD and WR, since only one burst is active.

Test Plan:
- Read req handle=1 addr=0x100 len=4 tag=5, no stalls -> DMA reads 0x100,0x104,0x108,0x10C; 4 beats with tag 5; last only on beat 4; rdy_readreq back to 1 the cycle after.
- Same read with en_readdata held low 3 cycles on beat 2 -> no further dma_en_readrequest until beat 2 is consumed; data order is intact.
- Write addr=0xFFFFFFFC len=2 tag=9, data 0xA,0xB -> write32 to 0xFFFFFFFC then 0x0; rdy_writedone with tag 9; IDLE after en_writedone.
- Read and write requests strobed together twice after reset -> read granted first, then write; only the winner's rdy is high each time.
- Read len=0 -> no DMA activity and no beats; following write len=1 proceeds normally.
- RST pulsed after 2 of 4 read beats -> all rdy/en outputs 0 during reset, then IDLE; a stale dma_rdy_readresponse is drained and no beat reaches the client.
